// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared 5-bit LFSR constants, sync states and next-bit function
package lfsr_pkg;
  localparam int LFSR_W = 5;
  localparam int TAP_A  = 4;
  localparam int TAP_B  = 2;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } sync_state_t;

  // s[0] holds the newest bit, so b[k] = b[k-5] ^ b[k-3] reads taps 4 and 2
  function automatic logic lfsr_next_bit(input logic [LFSR_W-1:0] s);
    return s[TAP_A] ^ s[TAP_B];
  endfunction
endpackage

// File: rtl/lfsr_err_counter.sv
// rtl/lfsr_err_counter.sv - saturating error counter with clear priority and registered pulse
module lfsr_err_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         pulse
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= inc;
      if (clr)
        cnt <= '0;
      else if (inc && (cnt != {W{1'b1}}))
        cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising 5-bit LFSR stream checker with lock and error counting
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT  = 8,
  parameter int LOSS_CNT  = 4,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rset_n,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 cnt_clr,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 stuck_zero,
  output logic [1:0]           state
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int NW = $clog2(LOSS_CNT + 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [NW-1:0] LOSS_LAST = NW'(LOSS_CNT - 1);

  sync_state_t       st;
  logic [LFSR_W-1:0] shadow;
  logic [2:0]        fill;
  logic [MW-1:0]     match;
  logic [NW-1:0]     miss;
  logic [2:0]        zrun;
  logic              pred;
  logic              err_inc;

  assign pred       = lfsr_next_bit(shadow);
  assign err_inc    = in_valid && (st == ST_LOCKED) && (in_bit != pred);
  assign stuck_zero = (zrun == 3'd5);
  assign state      = st;

  always_ff @(posedge clk or negedge rset_n) begin
    if (!rset_n) begin
      st     <= ST_SEED;
      shadow <= '0;
      fill   <= '0;
      match  <= '0;
      miss   <= '0;
      zrun   <= '0;
      locked <= 1'b0;
    end else if (in_valid) begin
      if (in_bit)
        zrun <= '0;
      else if (zrun != 3'd5)
        zrun <= zrun + 3'd1;

      case (st)
        ST_SEED: begin
          shadow <= {shadow[LFSR_W-2:0], in_bit};
          if (fill == 3'd4) begin
            st    <= ST_CHECK;
            fill  <= '0;
            match <= '0;
          end else begin
            fill <= fill + 3'd1;
          end
        end
        ST_CHECK: begin
          // Received bits are trusted here so a misaligned shadow re-seeds itself
          shadow <= {shadow[LFSR_W-2:0], in_bit};
          if ((in_bit == pred) && (shadow != '0)) begin
            match <= match + MW'(1);
            if (match == LOCK_LAST) begin
              st     <= ST_LOCKED;
              locked <= 1'b1;
              miss   <= '0;
            end
          end else begin
            match <= '0;
          end
        end
        ST_LOCKED: begin
          // Free-run on the prediction so one flipped bit costs exactly one error
          shadow <= {shadow[LFSR_W-2:0], pred};
          if (in_bit != pred) begin
            if (miss == LOSS_LAST) begin
              st     <= ST_SEED;
              locked <= 1'b0;
              fill   <= '0;
              miss   <= '0;
            end else begin
              miss <= miss + NW'(1);
            end
          end else begin
            miss <= '0;
          end
        end
        default: st <= ST_SEED;
      endcase
    end
  end

  lfsr_err_counter #(.W(ERR_CNT_W)) u_err_counter (
    .clk   (clk),
    .rst_n (rset_n),
    .clr   (cnt_clr),
    .inc   (err_inc),
    .cnt   (err_cnt),
    .pulse (err_pulse)
  );

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - directed self-checking bench for lfsr_checker (16-bit and 3-bit counters)
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        cnt_clr = 1'b0;

  logic        locked_a, err_pulse_a, stuck_zero_a;
  logic [15:0] err_cnt_a;
  logic [1:0]  state_a;
  logic        locked_b, err_pulse_b, stuck_zero_b;
  logic [2:0]  err_cnt_b;
  logic [1:0]  state_b;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;
  int pulses = 0;
  int lock_drops = 0;
  int stuck_seen = 0;
  bit [30:0] prbs;

  always #5 clk = ~clk;

  lfsr_checker dut_a (
    .clk(clk), .rset_n(rset_n), .in_valid(in_valid), .in_bit(in_bit), .cnt_clr(cnt_clr),
    .locked(locked_a), .err_pulse(err_pulse_a), .err_cnt(err_cnt_a),
    .stuck_zero(stuck_zero_a), .state(state_a)
  );

  lfsr_checker #(.ERR_CNT_W(3)) dut_b (
    .clk(clk), .rset_n(rset_n), .in_valid(in_valid), .in_bit(in_bit), .cnt_clr(cnt_clr),
    .locked(locked_b), .err_pulse(err_pulse_b), .err_cnt(err_cnt_b),
    .stuck_zero(stuck_zero_b), .state(state_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic b, input logic clr);
    in_valid = v;
    in_bit   = b;
    cnt_clr  = clr;
    @(posedge clk);
    #1;
    if (err_pulse_a) pulses++;
    if (stuck_zero_a) stuck_seen++;
  endtask

  task automatic gen_bit(input logic flip, input logic clr);
    step(1'b1, prbs[k % 31] ^ flip, clr);
    k++;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
    rset_n   = 1'b0;
    @(posedge clk);
    #1;
    rset_n = 1'b1;
    k = 0;
    pulses = 0;
    lock_drops = 0;
    stuck_seen = 0;
  endtask

  // Runs n stream bits, flipping global bit index flip_idx; gap inserts an idle cycle after each bit
  task automatic run_bits(input int n, input int flip_idx, input bit gap);
    for (int i = 0; i < n; i++) begin
      gen_bit(k == flip_idx, 1'b0);
      if (gap) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      if (k > 13 && !locked_a) lock_drops++;
    end
  endtask

  initial begin
    // b0..b30 of the sequence starting 0,0,1,0,1 (bit k at position k)
    prbs = 31'b1000_0101_0111_0110_0011_1110_0110_100;

    // 1: reset with random inputs
    rset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_bit   = 1'($urandom_range(0, 1));
      cnt_clr  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    check("rst_locked", {31'd0, locked_a}, 0);
    check("rst_pulse", {31'd0, err_pulse_a}, 0);
    check("rst_cnt", {16'd0, err_cnt_a}, 0);
    check("rst_stuck", {31'd0, stuck_zero_a}, 0);
    check("rst_state", {30'd0, state_a}, 0);
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
    rset_n   = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    check("idle_state", {30'd0, state_a}, 0);
    check("idle_locked", {31'd0, locked_a}, 0);

    // 2: clean stream, lock timing
    do_reset();
    for (int i = 0; i < 4; i++) gen_bit(1'b0, 1'b0);
    check("seed_state_bit4", {30'd0, state_a}, 0);
    gen_bit(1'b0, 1'b0);
    check("check_state_bit5", {30'd0, state_a}, 1);
    for (int i = 0; i < 7; i++) gen_bit(1'b0, 1'b0);
    check("unlocked_bit12", {31'd0, locked_a}, 0);
    gen_bit(1'b0, 1'b0);
    check("locked_bit13", {31'd0, locked_a}, 1);
    check("locked_state", {30'd0, state_a}, 2);
    run_bits(62, -1, 1'b0);
    check("clean_pulses", pulses, 0);
    check("clean_cnt", {16'd0, err_cnt_a}, 0);
    check("clean_stuck", stuck_seen, 0);
    check("clean_drops", lock_drops, 0);

    // 3: single flip at bit 30, continuous then gapped
    do_reset();
    run_bits(29, -1, 1'b0);
    gen_bit(1'b1, 1'b0);
    check("flip_pulse_next", {31'd0, err_pulse_a}, 1);
    run_bits(32, -1, 1'b0);
    check("flip_pulses", pulses, 1);
    check("flip_cnt", {16'd0, err_cnt_a}, 1);
    check("flip_drops", lock_drops, 0);
    do_reset();
    run_bits(62, 29, 1'b1);
    check("gap_pulses", pulses, 1);
    check("gap_cnt", {16'd0, err_cnt_a}, 1);
    check("gap_cnt_b", {29'd0, err_cnt_b}, 1);
    check("gap_drops", lock_drops, 0);

    // 4: four consecutive flips drop lock, clean bits relock
    do_reset();
    run_bits(20, -1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      gen_bit(1'b1, 1'b0);
      check("loss_pulse", {31'd0, err_pulse_a}, 1);
    end
    check("loss_locked_3", {31'd0, locked_a}, 1);
    gen_bit(1'b1, 1'b0);
    check("loss_pulse4", {31'd0, err_pulse_a}, 1);
    check("loss_locked_4", {31'd0, locked_a}, 0);
    check("loss_state", {30'd0, state_a}, 0);
    check("loss_cnt", {16'd0, err_cnt_a}, 4);
    for (int i = 0; i < 12; i++) gen_bit(1'b0, 1'b0);
    check("relock_bit12", {31'd0, locked_a}, 0);
    gen_bit(1'b0, 1'b0);
    check("relock_bit13", {31'd0, locked_a}, 1);
    check("relock_cnt", {16'd0, err_cnt_a}, 4);
    check("relock_pulses", pulses, 4);

    // async reset between edges
    @(negedge clk);
    rset_n = 1'b0;
    #1;
    check("async_locked", {31'd0, locked_a}, 0);
    check("async_cnt", {16'd0, err_cnt_a}, 0);
    check("async_state", {30'd0, state_a}, 0);
    @(negedge clk);
    rset_n = 1'b1;

    // 5: constant zero
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    check("stuck_4", {31'd0, stuck_zero_a}, 0);
    step(1'b1, 1'b0, 1'b0);
    check("stuck_5", {31'd0, stuck_zero_a}, 1);
    step(1'b0, 1'b1, 1'b0);
    check("stuck_gap", {31'd0, stuck_zero_a}, 1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
    check("stuck_nolock", {31'd0, locked_a}, 0);
    check("stuck_state", {30'd0, state_a}, 1);
    step(1'b1, 1'b1, 1'b0);
    check("stuck_clear", {31'd0, stuck_zero_a}, 0);

    // 6: saturation at 3 bits, clear beats error
    do_reset();
    run_bits(20, -1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      gen_bit(1'b1, 1'b0);
      run_bits(6, -1, 1'b0);
    end
    check("sat_cnt_b", {29'd0, err_cnt_b}, 7);
    check("sat_cnt_a", {16'd0, err_cnt_a}, 10);
    check("sat_locked", {31'd0, locked_b}, 1);
    gen_bit(1'b1, 1'b1);
    check("clr_pulse", {31'd0, err_pulse_b}, 1);
    check("clr_cnt_b", {29'd0, err_cnt_b}, 0);
    check("clr_cnt_a", {16'd0, err_cnt_a}, 0);
    gen_bit(1'b1, 1'b0);
    check("post_clr_cnt", {29'd0, err_cnt_b}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side companion to the team's 5-bit LFSR pattern generator.
- Consumes the generator's serial bit stream: one bit per valid cycle, the bit shifted into the generator's LSB each step.
- Self-synchronises a local copy of the LFSR, declares lock, then free-runs and counts bit errors for link and BIST checking.
- Sits at the far end of a serial test path, opposite the generator.

Parameters:
- LOCK_CNT, 8: consecutive matching bits needed in CHECK before lock is declared.
- LOSS_CNT, 4: consecutive mismatching bits in LOCKED that drop lock.
- ERR_CNT_W, 16: width of the saturating error counter.

Ports:
- clk  in  1  rising-edge clock
- rset_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_bit is sampled this cycle
- in_bit  in  1  received serial LFSR bit
- cnt_clr  in  1  synchronous clear of err_cnt
- locked  out  1  checker is locked and free-running
- err_pulse  out  1  one-cycle pulse per mismatch counted in LOCKED
- err_cnt  out  ERR_CNT_W  saturating mismatch count
- stuck_zero  out  1  5 or more consecutive zero bits received
- state  out  2  debug: 0=SEED, 1=CHECK, 2=LOCKED

Behaviour:
- Interface: one clock, clk; reset rset_n is asynchronous, active-low.
- Reset values: all outputs 0; state=SEED; shadow=0; fill/match/miss/zero-run counters 0.
- Reset asserted mid-operation clears everything immediately, regardless of clk.
- Sequence rule: b[k] = b[k-5] ^ b[k-3].
  - shadow[0] is the newest bit; predicted bit p = shadow[4] ^ shadow[2].
  - Period is 31; the longest legal zero run is 4.
- No state change when in_valid=0; gaps of any length are transparent.
- SEED:
  - Each valid bit shifts in: shadow <= {shadow[3:0], in_bit}.
  - After the 5th valid bit, go to CHECK with match=0.
- CHECK (self-synchronising):
  - Compare in_bit with p, then shift in in_bit (not p).
  - Match with shadow != 0: match++. Mismatch, or shadow == 0: match=0.
  - When match reaches LOCK_CNT, go to LOCKED; locked=1 from the next cycle.
  - err_cnt is never incremented in SEED or CHECK.
- LOCKED (free-running):
  - Shift in p (not in_bit), so one flipped received bit produces exactly one error.
  - Mismatch: err_pulse=1 in the following cycle, err_cnt++ (saturating at all ones), miss++.
  - Match: miss=0.
  - When miss reaches LOSS_CNT: go to SEED, locked=0 the next cycle, fill=0.
  - The mismatch that triggers loss is itself counted.
- Latency: err_pulse, locked and err_cnt update are registered, one cycle after the valid sample.
- cnt_clr: err_cnt=0 next cycle. cnt_clr together with an error gives err_cnt=0; clear wins.
- stuck_zero: a zero-run counter (saturating at 5) counts valid zero bits and resets on a valid one. stuck_zero = (run==5), independent of state.

Decomposition:
- Shared package lfsr_pkg:
  - LFSR_W=5, tap indices (4, 2), state encoding constants.
  - A function giving the next bit from a 5-bit state, shared with the generator.
- One natural sub-module, lfsr_err_counter: saturating counter with clear priority and pulse output.
- The sync FSM stays in the top module.

Test Plan:
1. Reset: hold rset_n=0 for 3 cycles with random inputs -> all outputs 0, state=0; release -> still 0 until valid data arrives.
2. Clean stream from generator seed 5'b00001 (bits 0,0,1,0,1,1,...), continuous in_valid -> state=1 after bit 5; locked=1 one cycle after bit 13; 62 further bits give err_cnt=0 and no err_pulse.
3. Same stream, single bit flipped at bit 30 -> exactly one err_pulse, err_cnt=1, locked stays 1; repeat with in_valid toggling 50% -> identical counts.
4. Locked, then 4 consecutive flipped bits -> 4 err_pulses, err_cnt=4, locked=0 after 4th; 13 clean bits later locked=1, err_cnt still 4.
5. Constant in_bit=0 -> stuck_zero=1 one cycle after 5th zero, never locks; a single 1 clears stuck_zero next cycle.
6. ERR_CNT_W=3, locked with 10 isolated flips -> err_cnt saturates at 7; cnt_clr asserted in the same cycle as an error -> err_cnt=0.
